// File: rtl/servo_pkg.sv
// servo_pkg: definitions shared by the servo PWM generator and the parent servo
// driver: manual direction encodings, default timing constants and the
// saturating arithmetic used for the position update.
package servo_pkg;

  // Manual direction encodings on DIR (2'b11 is treated as hold)
  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_CCW  = 2'b01;  // increase high time
  localparam logic [1:0] DIR_CW   = 2'b10;  // decrease high time

  // Default timing, in PWM ticks unless noted (100 MHz system clock)
  localparam int DEF_PRESCALE = 10;      // CLK cycles per tick -> 0.1 us
  localparam int DEF_PERIOD   = 200000;  // 20 ms
  localparam int DEF_PW_MIN   = 5000;    // 0.5 ms
  localparam int DEF_PW_RESET = 15000;   // 1.5 ms, centre
  localparam int DEF_STEP     = 10;

  // Position register width and the wider width used for add/subtract
  localparam int PW_W   = 15;
  localparam int CALC_W = 16;

  // a + b, clipped to hi. Inputs are zero-extended positions, so the sum
  // cannot wrap in CALC_W bits.
  function automatic logic [CALC_W-1:0] sat_add(input logic [CALC_W-1:0] a,
                                                input logic [CALC_W-1:0] b,
                                                input logic [CALC_W-1:0] hi);
    logic [CALC_W-1:0] sum;
    sum = a + b;
    return (sum > hi) ? hi : sum;
  endfunction

  // max(a - b, lo) without ever forming a negative intermediate.
  function automatic logic [CALC_W-1:0] sat_sub(input logic [CALC_W-1:0] a,
                                                input logic [CALC_W-1:0] b,
                                                input logic [CALC_W-1:0] lo);
    return (a >= (lo + b)) ? (a - b) : lo;
  endfunction

endpackage

// File: rtl/servo_pwm_ctrl_if.sv
// servo_pwm_ctrl_if: command/status bundle between the servo driver (master)
// and the PWM generator (slave).
//   DIR            driver -> gen  manual direction (servo_pkg DIR_*)
//   EN             driver -> gen  output enable
//   MC             driver -> gen  sweep restart (only while ES=1)
//   ES             driver -> gen  sweep enable
//   pulseWidth_max driver -> gen  upper high-time limit, ticks
//   pulseWidth     gen -> driver  current high time (servo position), ticks
//   SERVO          gen -> driver  PWM output
interface servo_pwm_ctrl_if;

  logic [1:0]                  DIR;
  logic                        EN;
  logic                        MC;
  logic                        ES;
  logic [servo_pkg::PW_W-1:0]  pulseWidth_max;
  logic [servo_pkg::PW_W-1:0]  pulseWidth;
  logic                        SERVO;

  modport master (
    output DIR, EN, MC, ES, pulseWidth_max,
    input  pulseWidth, SERVO
  );

  modport slave (
    input  DIR, EN, MC, ES, pulseWidth_max,
    output pulseWidth, SERVO
  );

endinterface

// File: rtl/servo_pwm_ctrl.sv
// servo_pwm_ctrl: fixed-period PWM generator whose high time (pulseWidth) is
// the servo position. The position moves once per period, at the last tick of
// the period, from manual DIR commands or an automatic sweep (ES/MC).
// Ports:
//   CLK  system clock
//   RST  asynchronous active-low reset
//   bus  servo_pwm_ctrl_if.slave (commands in, pulseWidth/SERVO out)
module servo_pwm_ctrl
  import servo_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int PERIOD   = DEF_PERIOD,
  parameter int PW_MIN   = DEF_PW_MIN,
  parameter int PW_RESET = DEF_PW_RESET,
  parameter int STEP     = DEF_STEP
) (
  input  logic            CLK,
  input  logic            RST,
  servo_pwm_ctrl_if.slave bus
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PCNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [PCNT_W-1:0]  PCNT_LAST  = PCNT_W'(PERIOD - 1);
  localparam logic [CALC_W-1:0]  PW_MIN_C   = CALC_W'(PW_MIN);
  localparam logic [CALC_W-1:0]  STEP_C     = CALC_W'(STEP);
  localparam logic [PW_W-1:0]    PW_RESET_C = PW_W'(PW_RESET);

  logic [PRESC_W-1:0] presc_r;
  logic [PCNT_W-1:0]  pcnt_r;
  logic [PW_W-1:0]    pw_r;
  logic               servo_r;

  logic               tick_s;
  logic               eop_s;
  logic [CALC_W-1:0]  cur_s;
  logic [CALC_W-1:0]  lim_s;
  logic [PW_W-1:0]    pw_next_s;

  assign tick_s = (presc_r == PRESC_LAST);
  assign eop_s  = tick_s && (pcnt_r == PCNT_LAST);

  // Prescaler: one tick every PRESCALE clocks
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

  // Period counter: advances per tick, wraps after the last tick of a period
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pcnt_r <= '0;
    end else if (eop_s) begin
      pcnt_r <= '0;
    end else if (tick_s) begin
      pcnt_r <= pcnt_r + PCNT_W'(1);
    end else begin
      pcnt_r <= pcnt_r;
    end
  end

  // Next position, evaluated every cycle but only committed at end of period.
  // All arithmetic is done in CALC_W bits so nothing can wrap before clipping.
  always_comb begin
    cur_s     = CALC_W'(pw_r);
    // A limit below PW_MIN would contradict the lower bound; PW_MIN wins.
    lim_s     = (CALC_W'(bus.pulseWidth_max) > PW_MIN_C) ?
                CALC_W'(bus.pulseWidth_max) : PW_MIN_C;
    pw_next_s = pw_r;
    if (bus.ES && bus.MC) begin
      pw_next_s = PW_W'(PW_MIN_C);
    end else if (bus.ES) begin
      // Sweep overrides manual direction
      pw_next_s = PW_W'(sat_add(cur_s, STEP_C, lim_s));
    end else begin
      case (bus.DIR)
        DIR_CCW: pw_next_s = PW_W'(sat_add(cur_s, STEP_C, lim_s));
        DIR_CW:  pw_next_s = PW_W'(sat_sub(cur_s, STEP_C, PW_MIN_C));
        // Hold, but pull back inside a limit that was lowered under us
        default: pw_next_s = PW_W'((cur_s > lim_s) ? lim_s : cur_s);
      endcase
    end
  end

  // Position register: changes only at end of period, so a period never
  // sees its high time change part way through
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pw_r <= PW_RESET_C;
    end else if (eop_s) begin
      pw_r <= pw_next_s;
    end else begin
      pw_r <= pw_r;
    end
  end

  // PWM output, one clock behind pcnt; positions >= PERIOD give a constant high
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      servo_r <= 1'b0;
    end else begin
      servo_r <= bus.EN & (32'(pcnt_r) < 32'(pw_r));
    end
  end

  assign bus.pulseWidth = pw_r;
  assign bus.SERVO      = servo_r;

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Testbench for servo_pwm_ctrl with PRESCALE=1, PERIOD=100, PW_MIN=10,
// PW_RESET=50, STEP=5. A cycle-level reference model (period offset from an
// edge count, position rules in plain integer arithmetic) checks SERVO and
// pulseWidth after every clock edge, plus per-period high-time totals.
module tb_servo_pwm_ctrl;

  localparam int PER   = 100;
  localparam int PWMIN = 10;
  localparam int PWRST = 50;
  localparam int STP   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  servo_pwm_ctrl_if bus();

  servo_pwm_ctrl #(
    .PRESCALE(1),
    .PERIOD  (PER),
    .PW_MIN  (PWMIN),
    .PW_RESET(PWRST),
    .STEP    (STP)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int n    = 0;      // clock edges since reset release
  int pw_m = PWRST;  // model position

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Position rule for one end-of-period sample, straight from the update list
  function automatic int ref_next(int pw, int dir, int es, int mc, int mx);
    int lim;
    lim = (mx > PWMIN) ? mx : PWMIN;
    if (es != 0 && mc != 0) return PWMIN;
    if (es != 0)            return (pw + STP < lim) ? pw + STP : lim;
    if (dir == 1)           return (pw + STP < lim) ? pw + STP : lim;
    if (dir == 2)           return (pw - STP > PWMIN) ? pw - STP : PWMIN;
    return (pw > lim) ? lim : pw;
  endfunction

  // One clock: predict from inputs seen at the edge, then check 1 ns later
  task automatic step();
    int   off;
    logic exp_servo;
    @(posedge clk);
    off = n % PER;
    n++;
    exp_servo = bus.EN && (off < pw_m);
    if (off == PER - 1)
      pw_m = ref_next(pw_m, int'(bus.DIR), int'(bus.ES), int'(bus.MC), int'(bus.pulseWidth_max));
    #1;
    chk("servo", 32'(bus.SERVO), 32'(exp_servo));
    chk("pulse_width", 32'(bus.pulseWidth), 32'(pw_m));
  endtask

  // One full period from offset 0, also checking the total high time
  task automatic run_period();
    int highs;
    int exp_highs;
    exp_highs = bus.EN ? ((pw_m < PER) ? pw_m : PER) : 0;
    highs = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      if (bus.SERVO === 1'b1) highs++;
    end
    chk("high_time", 32'(highs), 32'(exp_highs));
  endtask

  task automatic run_periods(input int k);
    for (int i = 0; i < k; i++) run_period();
  endtask

  task automatic run_to_period_end();
    for (int i = 0; i < PER && (n % PER) != 0; i++) step();
  endtask

  task automatic set_cmd(input logic [1:0] dir, input logic es, input logic mc, input int mx);
    bus.DIR = dir;
    bus.ES = es;
    bus.MC = mc;
    bus.pulseWidth_max = 15'(mx);
  endtask

  initial begin
    bus.EN = 1'b1;
    set_cmd(2'b00, 1'b0, 1'b0, 70);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_servo", 32'(bus.SERVO), 32'd0);
    chk("reset_pw", 32'(bus.pulseWidth), 32'(PWRST));
    rst_n = 1'b1;
    n = 0;
    pw_m = PWRST;

    // Hold: 50 of 100 high, position fixed
    run_periods(2);
    chk("hold_pw", 32'(bus.pulseWidth), 32'd50);

    // CCW up to the limit 70, then saturate
    set_cmd(2'b01, 1'b0, 1'b0, 70);
    run_periods(6);
    chk("ccw_sat", 32'(bus.pulseWidth), 32'd70);

    // CW down to PW_MIN and saturate
    set_cmd(2'b10, 1'b0, 1'b0, 70);
    run_periods(14);
    chk("cw_sat", 32'(bus.pulseWidth), 32'd10);

    // Sweep ignores DIR=CW and climbs to the limit
    set_cmd(2'b10, 1'b1, 1'b0, 70);
    run_periods(13);
    chk("sweep_max", 32'(bus.pulseWidth), 32'd70);
    // Sweep restart
    set_cmd(2'b10, 1'b1, 1'b1, 70);
    run_period();
    chk("sweep_restart", 32'(bus.pulseWidth), 32'd10);
    // MC without ES does nothing
    set_cmd(2'b00, 1'b0, 1'b1, 70);
    run_period();
    chk("mc_no_es", 32'(bus.pulseWidth), 32'd10);

    // Lowering the limit below the position clamps it on hold
    set_cmd(2'b01, 1'b0, 1'b0, 70);
    run_periods(12);
    set_cmd(2'b00, 1'b0, 1'b0, 60);
    run_period();
    chk("clamp_60", 32'(bus.pulseWidth), 32'd60);

    // EN drop mid-pulse forces SERVO low within one clock
    for (int i = 0; i < 20; i++) step();
    bus.EN = 1'b0;
    step();
    chk("en_low", 32'(bus.SERVO), 32'd0);
    bus.EN = 1'b1;
    run_to_period_end();

    // Limit below PW_MIN is raised to PW_MIN
    set_cmd(2'b00, 1'b0, 1'b0, 3);
    run_period();
    chk("lim_floor", 32'(bus.pulseWidth), 32'd10);

    // Randomised commands, one set per period; limits above PERIOD allowed
    for (int i = 0; i < 40; i++) begin
      set_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 120)));
      bus.EN = 1'($urandom_range(0, 4) != 0);
      run_period();
    end

    // Reset in the middle of a pulse
    bus.EN = 1'b1;
    set_cmd(2'b01, 1'b0, 1'b0, 80);
    run_periods(2);
    for (int i = 0; i < 5; i++) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_servo", 32'(bus.SERVO), 32'd0);
    chk("midreset_pw", 32'(bus.pulseWidth), 32'(PWRST));
    n = 0;
    pw_m = PWRST;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_cmd(2'b00, 1'b0, 1'b0, 70);
    run_period();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
